stopwatch_ctrl: RTL and testbench

Run-control sequencer for the 4-digit stopwatch counter chain (0.1 s, 1 s, 10 s, 100 s decade counters). It takes debounced single-cycle button pulses and produces the 0.1 s count enable, a synchronous clear, and lap-hold control for the display path. It also detects 999.9 overflow and freezes the count there. It sits between the debounce stage and the decade counters/7-segment mux, and it replaces the ad-hoc state toggle and prescaler.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_ctrl_prescaler.sv | 29 ++
 rtl/stopwatch_ctrl.sv | 114 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run-control sequencer.
package stopwatch_pkg;
   localparam int TICK_DIV_DEFAULT = 1_000_000;
   localparam int STATE_W          = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_PAUSED = 3'd2,
      ST_LAP    = 3'd3,
      ST_OVF    = 3'd4
   } sw_state_e;

   function automatic logic is_counting(input sw_state_e s);
      return (s == ST_RUN) || (s == ST_LAP);
   endfunction
endpackage

// File: rtl/stopwatch_ctrl_prescaler.sv
// 0.1 s prescaler: counts 0..TICK_DIV-1 while enabled, flags the wrap cycle.
module tick_prescaler #(
   parameter  int TICK_DIV = 4,
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic             clk0,
   input  logic             reset_sw_n,
   input  logic             en,
   input  logic             sclr,
   output logic             wrap,
   output logic [PRE_W-1:0] count
);
   localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] r_cnt;
   logic             w_wrap;

   // wrap is raw (not masked by sclr); the controller decides what a wrap means
   assign w_wrap = en && (r_cnt == LAST);

   always_ff @(posedge clk0 or negedge reset_sw_n) begin
      if (!reset_sw_n)  r_cnt <= '0;
      else if (sclr)    r_cnt <= '0;
      else if (en)      r_cnt <= w_wrap ? '0 : r_cnt + PRE_W'(1);
   end

   assign wrap  = w_wrap;
   assign count = r_cnt;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control FSM: button pulses in, count enable / clear / lap-hold out.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter  int TICK_DIV = TICK_DIV_DEFAULT,
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic               clk0,
   input  logic               reset_sw_n,
   input  logic               start_p,
   input  logic               lap_p,
   input  logic               clr_p,
   input  logic               at_max,
   output logic               tick_en,
   output logic               cnt_clr,
   output logic               lap_load,
   output logic               disp_hold,
   output logic               run,
   output logic               ovf,
   output logic [STATE_W-1:0] state
);
   sw_state_e        r_state, w_nxt_state;
   logic             r_tick, r_clr, r_lap_load, r_disp_hold, r_run, r_ovf;
   logic             w_tick, w_clr, w_lap_load, w_hold;
   logic             w_wrap, w_pre_en, w_pre_sclr;
   logic [PRE_W-1:0] w_pre_cnt;

   // Prescaler advance is decided by the registered state, never the pulse
   assign w_pre_en   = is_counting(r_state);
   assign w_pre_sclr = clr_p || ((r_state == ST_IDLE) && start_p);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
      .clk0       (clk0),
      .reset_sw_n (reset_sw_n),
      .en         (w_pre_en),
      .sclr       (w_pre_sclr),
      .wrap       (w_wrap),
      .count      (w_pre_cnt)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_tick      = 1'b0;
      w_clr       = 1'b0;
      w_lap_load  = 1'b0;
      w_hold      = r_disp_hold;
      if (clr_p) begin
         w_nxt_state = ST_IDLE;
         w_clr       = 1'b1;
         w_hold      = 1'b0;
      end else begin
         w_tick = w_wrap && !at_max;
         case (r_state)
            ST_IDLE:   if (start_p) w_nxt_state = ST_RUN;
            ST_RUN: begin
               if (start_p) w_nxt_state = ST_PAUSED;
               else if (lap_p) begin
                  w_nxt_state = ST_LAP;
                  w_lap_load  = 1'b1;
                  w_hold      = 1'b1;
               end
            end
            ST_PAUSED: if (start_p) w_nxt_state = ST_RUN;
            ST_LAP: begin
               if (start_p || lap_p) begin
                  w_nxt_state = start_p ? ST_PAUSED : ST_RUN;
                  w_hold      = 1'b0;
               end
            end
            ST_OVF:    w_nxt_state = ST_OVF;
            default:   w_nxt_state = ST_IDLE;
         endcase
         // Reaching 999.9 overrides any button action in the same cycle
         if (w_wrap && at_max) begin
            w_nxt_state = ST_OVF;
            w_lap_load  = 1'b0;
            w_hold      = r_disp_hold;
         end
      end
   end

   always_ff @(posedge clk0 or negedge reset_sw_n) begin
      if (!reset_sw_n) begin
         r_state     <= ST_IDLE;
         r_tick      <= 1'b0;
         r_clr       <= 1'b0;
         r_lap_load  <= 1'b0;
         r_disp_hold <= 1'b0;
         r_run       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_tick      <= w_tick;
         r_clr       <= w_clr;
         r_lap_load  <= w_lap_load;
         r_disp_hold <= w_hold;
         r_run       <= is_counting(w_nxt_state);
         r_ovf       <= (w_nxt_state == ST_OVF);
      end
   end

   assign tick_en   = r_tick;
   assign cnt_clr   = r_clr;
   assign lap_load  = r_lap_load;
   assign disp_hold = r_disp_hold;
   assign run       = r_run;
   assign ovf       = r_ovf;
   assign state     = r_state;

   a_pre_range: assert property (@(posedge clk0) disable iff (!reset_sw_n)
      w_pre_cnt <= PRE_W'(TICK_DIV - 1));
   a_tick_clr_excl: assert property (@(posedge clk0) disable iff (!reset_sw_n)
      !(r_tick && r_clr));
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;
   logic       clk0 = 1'b0;
   logic       reset_sw_n = 1'b0;
   logic       start_p = 1'b0, lap_p = 1'b0, clr_p = 1'b0, at_max = 1'b0;
   logic       tick_en, cnt_clr, lap_load, disp_hold, run, ovf;
   logic [2:0] state;
   logic [8:0] obs, exp_v;
   int         n_tests = 0, n_fail = 0;

   // obs = {tick_en, cnt_clr, lap_load, disp_hold, run, ovf, state}
   localparam logic [8:0] IDLE_S = 9'b000000_000;
   localparam logic [8:0] CLR_S  = 9'b010000_000;
   localparam logic [8:0] RUN_S  = 9'b000010_001;
   localparam logic [8:0] RUN_T  = 9'b100010_001;
   localparam logic [8:0] PAU_S  = 9'b000000_010;
   localparam logic [8:0] PAU_T  = 9'b100000_010;
   localparam logic [8:0] LAP_H  = 9'b000110_011;
   localparam logic [8:0] LAP_L  = 9'b001110_011;
   localparam logic [8:0] LAP_T  = 9'b100110_011;
   localparam logic [8:0] LAP_LT = 9'b101110_011;
   localparam logic [8:0] OVF_S  = 9'b000001_100;

   assign obs = {tick_en, cnt_clr, lap_load, disp_hold, run, ovf, state};

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .clk0(clk0), .reset_sw_n(reset_sw_n), .start_p(start_p), .lap_p(lap_p),
      .clr_p(clr_p), .at_max(at_max), .tick_en(tick_en), .cnt_clr(cnt_clr),
      .lap_load(lap_load), .disp_hold(disp_hold), .run(run), .ovf(ovf),
      .state(state)
   );

   always #5 clk0 = ~clk0;

   task automatic step();
      @(posedge clk0);
      #1;
   endtask

   task automatic pulse(input logic s, input logic l, input logic c);
      start_p = s; lap_p = l; clr_p = c;
      step();
      start_p = 1'b0; lap_p = 1'b0; clr_p = 1'b0;
   endtask

   task automatic test_reset();
      reset_sw_n = 1'b0;
      repeat (3) step();
      n_tests++;
      if (obs !== IDLE_S) begin
         n_fail++; $display("FAIL reset_held obs=%b exp=%b", obs, IDLE_S);
      end
      reset_sw_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         n_tests++;
         if (obs !== IDLE_S) begin
            n_fail++; $display("FAIL reset_idle c%0d obs=%b exp=%b", i, obs, IDLE_S);
         end
      end
   endtask

   task automatic test_run();
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         exp_v = (c == 5 || c == 9 || c == 13) ? RUN_T : RUN_S;
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL run_ticks c%0d obs=%b exp=%b", c, obs, exp_v);
         end
         step();
      end
      pulse(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (obs !== CLR_S) begin
         n_fail++; $display("FAIL run_clr obs=%b exp=%b", obs, CLR_S);
      end
      step();
      n_tests++;
      if (obs !== IDLE_S) begin
         n_fail++; $display("FAIL run_clr_done obs=%b exp=%b", obs, IDLE_S);
      end
   endtask

   task automatic test_pause();
      pulse(1'b1, 1'b0, 1'b0);
      step();
      pulse(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         n_tests++;
         if (obs !== PAU_S) begin
            n_fail++; $display("FAIL pause_hold p%0d obs=%b exp=%b", i, obs, PAU_S);
         end
         step();
      end
      pulse(1'b1, 1'b0, 1'b0);
      for (int r = 0; r <= 6; r++) begin
         exp_v = (r == 2 || r == 6) ? RUN_T : RUN_S;
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL pause_resume r%0d obs=%b exp=%b", r, obs, exp_v);
         end
         step();
      end
      pulse(1'b0, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_lap();
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      for (int c = 2; c <= 5; c++) begin
         exp_v = (c == 2) ? LAP_L : (c == 5) ? LAP_T : LAP_H;
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL lap_enter c%0d obs=%b exp=%b", c, obs, exp_v);
         end
         if (c < 5) step();
      end
      pulse(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== RUN_S) begin
         n_fail++; $display("FAIL lap_exit obs=%b exp=%b", obs, RUN_S);
      end
      pulse(1'b0, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_ovf();
      pulse(1'b1, 1'b0, 1'b0);
      at_max = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         n_tests++;
         if (obs !== RUN_S) begin
            n_fail++; $display("FAIL ovf_pre c%0d obs=%b exp=%b", c, obs, RUN_S);
         end
         step();
      end
      n_tests++;
      if (obs !== OVF_S) begin
         n_fail++; $display("FAIL ovf_enter obs=%b exp=%b", obs, OVF_S);
      end
      pulse(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (obs !== OVF_S) begin
         n_fail++; $display("FAIL ovf_start_ign obs=%b exp=%b", obs, OVF_S);
      end
      pulse(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== OVF_S) begin
         n_fail++; $display("FAIL ovf_lap_ign obs=%b exp=%b", obs, OVF_S);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         n_tests++;
         if (obs !== OVF_S) begin
            n_fail++; $display("FAIL ovf_stay i%0d obs=%b exp=%b", i, obs, OVF_S);
         end
      end
      at_max = 1'b0;
      pulse(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (obs !== CLR_S) begin
         n_fail++; $display("FAIL ovf_clr obs=%b exp=%b", obs, CLR_S);
      end
      step();
      n_tests++;
      if (obs !== IDLE_S) begin
         n_fail++; $display("FAIL ovf_clr_done obs=%b exp=%b", obs, IDLE_S);
      end
   endtask

   task automatic test_simul();
      // clr+start on a wrap cycle
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) step();
      pulse(1'b1, 1'b0, 1'b1);
      n_tests++;
      if (obs !== CLR_S) begin
         n_fail++; $display("FAIL wrap_clr obs=%b exp=%b", obs, CLR_S);
      end
      step();
      n_tests++;
      if (obs !== IDLE_S) begin
         n_fail++; $display("FAIL wrap_clr_idle obs=%b exp=%b", obs, IDLE_S);
      end
      // prescaler must restart from 0
      pulse(1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         exp_v = (c == 5) ? RUN_T : RUN_S;
         n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL restart c%0d obs=%b exp=%b", c, obs, exp_v);
         end
         if (c < 5) step();
      end
      // start on a wrap cycle: tick still issued, then PAUSED
      repeat (3) step();
      pulse(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (obs !== PAU_T) begin
         n_fail++; $display("FAIL wrap_start obs=%b exp=%b", obs, PAU_T);
      end
      step();
      n_tests++;
      if (obs !== PAU_S) begin
         n_fail++; $display("FAIL wrap_start_after obs=%b exp=%b", obs, PAU_S);
      end
      pulse(1'b0, 1'b0, 1'b1);
      step();
      // lap on a wrap cycle: tick and lap_load together
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) step();
      pulse(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (obs !== LAP_LT) begin
         n_fail++; $display("FAIL wrap_lap obs=%b exp=%b", obs, LAP_LT);
      end
      step();
      n_tests++;
      if (obs !== LAP_H) begin
         n_fail++; $display("FAIL wrap_lap_after obs=%b exp=%b", obs, LAP_H);
      end
      pulse(1'b0, 1'b0, 1'b1);
      step();
   endtask

   task automatic test_reset_mid();
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) step();
      #2 reset_sw_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== IDLE_S) begin
         n_fail++; $display("FAIL reset_async obs=%b exp=%b", obs, IDLE_S);
      end
      repeat (2) step();
      reset_sw_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_tests++;
         if (obs !== IDLE_S) begin
            n_fail++; $display("FAIL reset_release i%0d obs=%b exp=%b", i, obs, IDLE_S);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_pause();
      test_lap();
      test_ovf();
      test_simul();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
